// File: rtl/cache_line_array_pkg.sv
// Shared types and default sizing for the cache line array and its flush controller.
package lc3b_types;

   localparam int DEFAULT_WIDTH = 128;
   localparam int DEFAULT_SETS  = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } flush_state_t;

endpackage : lc3b_types

// File: rtl/array_flush_ctrl.sv
// Flush sequencer: walks every line once, emitting a clear strobe and the line index.
module array_flush_ctrl
   import lc3b_types::*;
#(
   parameter int SETS = DEFAULT_SETS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   output logic                    busy,
   output logic                    clear,
   output logic [$clog2(SETS)-1:0] index
);

   localparam int IW = $clog2(SETS);
   localparam logic [IW-1:0] LAST = IW'(SETS - 1);

   flush_state_t state;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         index <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (flush) begin
                  state <= FLUSH;
                  index <= '0;
                  busy  <= 1'b1;
               end
            end
            FLUSH: begin
               // The index parks on the last line rather than wrapping; the next flush reloads it.
               if (index == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  index <= index + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign clear = (state == FLUSH);

endmodule : array_flush_ctrl

// File: rtl/cache_line_array.sv
// Line storage with byte-masked writes, per-line valid bits and a sequential flush.
// Optional per-byte even parity and parity_err output when CACHE_ARRAY_PARITY_EN is defined.
module cache_line_array
   import lc3b_types::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int SETS  = DEFAULT_SETS
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    write,
   input  logic [$clog2(SETS)-1:0] set,
   input  logic [WIDTH/8-1:0]      wmask,
   input  logic [WIDTH-1:0]        datain,
   input  logic                    flush,
   output logic [WIDTH-1:0]        dataout,
   output logic                    valid_out,
`ifdef CACHE_ARRAY_PARITY_EN
   output logic                    parity_err,
`endif
   output logic                    busy
);

   localparam int NB = WIDTH / 8;
   localparam int IW = $clog2(SETS);

   // NOTE: line data is deliberately not reset; it powers up as zero and only valid bits are cleared.
   logic [WIDTH-1:0] data_q [SETS] = '{default: '0};
   logic [SETS-1:0]  valid_q;

   logic          clear;
   logic [IW-1:0] clear_idx;
   logic          write_ok;
   logic [WIDTH-1:0] merged;

   array_flush_ctrl #(.SETS(SETS)) u_flush_ctrl (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .busy  (busy),
      .clear (clear),
      .index (clear_idx)
   );

   // Flush wins over a simultaneous write, and writes are dropped while the flush walks the lines.
   assign write_ok = write && !busy && !flush && !reset;

   // NOTE: every combinational output gets a default first, so no latch is inferred.
   always_comb begin
      merged = data_q[set];
      for (int b = 0; b < NB; b++) begin
         if (wmask[b]) merged[8*b +: 8] = datain[8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (write_ok) data_q[set] <= merged;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
      end else begin
         if (clear)    valid_q[clear_idx] <= 1'b0;
         if (write_ok) valid_q[set]       <= 1'b1;
      end
   end

   assign dataout   = data_q[set];
   assign valid_out = valid_q[set];

`ifdef CACHE_ARRAY_PARITY_EN
   logic [NB-1:0] par_q [SETS] = '{default: '0};
   logic [NB-1:0] par_merged;
   logic [NB-1:0] par_calc;

   always_comb begin
      par_merged = par_q[set];
      par_calc   = '0;
      for (int b = 0; b < NB; b++) begin
         if (wmask[b]) par_merged[b] = ^datain[8*b +: 8];
         par_calc[b] = ^data_q[set][8*b +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (write_ok) par_q[set] <= par_merged;
   end

   assign parity_err = valid_q[set] && (|(par_calc ^ par_q[set]));
`endif

endmodule : cache_line_array

// File: tb/tb_cache_line_array.sv
// Directed self-checking bench for cache_line_array (WIDTH=128, SETS=8).
module tb_cache_line_array;

   localparam int WIDTH = 128;
   localparam int SETS  = 8;
   localparam int NB    = WIDTH / 8;

   logic             clk = 1'b0;
   logic             reset;
   logic             write;
   logic [2:0]       set;
   logic [NB-1:0]    wmask;
   logic [WIDTH-1:0] datain;
   logic             flush;
   logic [WIDTH-1:0] dataout;
   logic             valid_out;
   logic             busy;
`ifdef CACHE_ARRAY_PARITY_EN
   logic             parity_err;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] exp_data [SETS];

   cache_line_array #(.WIDTH(WIDTH), .SETS(SETS)) dut (
      .clk       (clk),
      .reset     (reset),
      .write     (write),
      .set       (set),
      .wmask     (wmask),
      .datain    (datain),
      .flush     (flush),
      .dataout   (dataout),
      .valid_out (valid_out),
`ifdef CACHE_ARRAY_PARITY_EN
      .parity_err(parity_err),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [2:0] s, input logic [NB-1:0] m, input logic [WIDTH-1:0] d);
      write = 1'b1; set = s; wmask = m; datain = d;
      tick();
      write = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; write = 1'b0; flush = 1'b0; set = '0; wmask = '0; datain = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      for (int s = 0; s < SETS; s++) begin
         set = 3'(s); #1;
         exp_data[s] = '0;
         n_checks++;
         if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid set %0d: got %b want 0", s, valid_out); end
         n_checks++;
         if (dataout !== '0) begin n_fail++; $display("FAIL reset_data set %0d: got %h want 0", s, dataout); end
      end
   endtask

   task automatic test_masked_write();
      logic [WIDTH-1:0] want;
      do_write(3'd3, '1, {4{32'hDEADBEEF}});
      do_write(3'd3, 16'h0001, {16{8'hAA}});
      want = {{3{32'hDEADBEEF}}, 32'hDEADBEAA};
      exp_data[3] = want;
      set = 3'd3; #1;
      n_checks++;
      if (dataout !== want) begin n_fail++; $display("FAIL masked_data: got %h want %h", dataout, want); end
      n_checks++;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL masked_valid: got %b want 1", valid_out); end
      // Zero mask: valid goes high, data untouched.
      do_write(3'd4, '0, {WIDTH{1'b1}});
      set = 3'd4; #1;
      n_checks++;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL zero_mask_valid: got %b want 1", valid_out); end
      n_checks++;
      if (dataout !== '0) begin n_fail++; $display("FAIL zero_mask_data: got %h want 0", dataout); end
   endtask

   task automatic test_flush();
      int cnt;
      for (int s = 0; s < SETS; s++) begin
         exp_data[s] = {16{8'(8'h10 + s)}};
         do_write(3'(s), '1, exp_data[s]);
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      cnt = 0;
      while (busy === 1'b1 && cnt < 20) begin cnt++; tick(); end
      n_checks++;
      if (cnt !== 8) begin n_fail++; $display("FAIL flush_busy_cycles: got %0d want 8", cnt); end
      for (int s = 0; s < SETS; s++) begin
         set = 3'(s); #1;
         n_checks++;
         if (valid_out !== 1'b0) begin n_fail++; $display("FAIL flush_valid set %0d: got %b want 0", s, valid_out); end
         n_checks++;
         if (dataout !== exp_data[s]) begin n_fail++; $display("FAIL flush_data set %0d: got %h want %h", s, dataout, exp_data[s]); end
      end
   endtask

   task automatic test_flush_write_conflict();
      int cnt;
      do_write(3'd5, '1, exp_data[5]);
      do_write(3'd2, '1, exp_data[2]);
      // Flush and write together: write dropped.
      flush = 1'b1; write = 1'b1; set = 3'd5; wmask = '1; datain = {WIDTH{1'b1}};
      tick();
      // During busy: write to set 2 and a second flush request are both ignored.
      flush = 1'b1; write = 1'b1; set = 3'd2; wmask = '1; datain = {WIDTH{1'b1}};
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL conflict_busy_rise: got %b want 1", busy); end
      cnt = 0;
      while (busy === 1'b1 && cnt < 20) begin
         cnt++;
         tick();
         if (cnt == 1) flush = 1'b0;
      end
      write = 1'b0; flush = 1'b0;
      n_checks++;
      if (cnt !== 8) begin n_fail++; $display("FAIL conflict_busy_cycles: got %0d want 8", cnt); end
      foreach (exp_data[s]) begin
         if (s == 5 || s == 2) begin
            set = 3'(s); #1;
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL conflict_valid set %0d: got %b want 0", s, valid_out); end
            n_checks++;
            if (dataout !== exp_data[s]) begin n_fail++; $display("FAIL conflict_data set %0d: got %h want %h", s, dataout, exp_data[s]); end
         end
      end
   endtask

   task automatic test_reset_during_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL midflush_busy: got %b want 1", busy); end
      reset = 1'b1; write = 1'b1; set = 3'd1; wmask = '1; datain = '0;
      tick();
      reset = 1'b0; write = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
      set = 3'd1; #1;
      n_checks++;
      if (dataout !== exp_data[1]) begin n_fail++; $display("FAIL reset_prio_data: got %h want %h", dataout, exp_data[1]); end
      n_checks++;
      if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_prio_valid: got %b want 0", valid_out); end
      exp_data[6] = {4{32'hCAFEF00D}};
      do_write(3'd6, '1, exp_data[6]);
      set = 3'd6; #1;
      n_checks++;
      if (valid_out !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid: got %b want 1", valid_out); end
      n_checks++;
      if (dataout !== exp_data[6]) begin n_fail++; $display("FAIL post_reset_data: got %h want %h", dataout, exp_data[6]); end
   endtask

`ifdef CACHE_ARRAY_PARITY_EN
   task automatic test_parity();
      do_write(3'd1, '1, {4{32'h12345678}});
      do_write(3'd0, '1, {4{32'h0F0F0F0F}});
      set = 3'd1; #1;
      n_checks++;
      if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_clean: got %b want 0", parity_err); end
      dut.data_q[1][0] = ~dut.data_q[1][0];
      #1;
      n_checks++;
      if (parity_err !== 1'b1) begin n_fail++; $display("FAIL parity_err_set1: got %b want 1", parity_err); end
      set = 3'd0; #1;
      n_checks++;
      if (parity_err !== 1'b0) begin n_fail++; $display("FAIL parity_err_set0: got %b want 0", parity_err); end
   endtask
`endif

   initial begin
      test_reset();
      test_masked_write();
      test_flush();
      test_flush_write_conflict();
      test_reset_during_flush();
`ifdef CACHE_ARRAY_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_cache_line_array
